// File: rtl/z80_bus_master.sv
// z80_bus_master: Z80-style bus initiator. Converts single-word commands
// (memrd/memwr/iord/iowr) into T-state timed bus cycles with WAIT support.
// One T-state is two clk cycles (H phase then L phase). All bus outputs are
// registered and are computed from the next FSM state, so every strobe edge
// lands on a clk edge.
//
// Command handshake: a command is transferred on a rising clk edge where
// rdy_o=1 and req_i=1; cmd_i/addr_i/wdata_i are captured on that edge.
// rdy_o drops on the following clk and returns high together with the
// one-clk done_o pulse. req_i while rdy_o=0 is ignored, never queued.
module z80_bus_master #(
  parameter int IO_TW  = 1,  // automatic wait T-states in every IO cycle
  parameter int MEM_TW = 0   // automatic wait T-states in every memory cycle
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic [1:0]  cmd_i,
  input  logic [15:0] addr_i,
  input  logic [7:0]  wdata_i,
  output logic        rdy_o,
  output logic        done_o,
  output logic [7:0]  rdata_o,
  output logic [15:0] a_o,
  output logic [7:0]  d_out_o,
  output logic        d_oe_o,
  input  logic [7:0]  d_in_i,
  output logic        mreq_n_o,
  output logic        iorq_n_o,
  output logic        rd_n_o,
  output logic        wr_n_o,
  input  logic        wait_n_i,
  output logic [3:0]  dbg_state_o
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T1H  = 4'd1,
    S_T1L  = 4'd2,
    S_T2H  = 4'd3,
    S_T2L  = 4'd4,
    S_TWH  = 4'd5,
    S_TWL  = 4'd6,
    S_T3H  = 4'd7,
    S_T3L  = 4'd8
  } state_t;

  localparam logic [7:0] IO_TW_L  = 8'(IO_TW);
  localparam logic [7:0] MEM_TW_L = 8'(MEM_TW);

  // FSM and command registers
  state_t      state_q, state_d;
  logic [1:0]  cmd_q, cmd_d;
  logic [7:0]  tw_cnt_q, tw_cnt_d;

  // Registered bus outputs
  logic        rdy_q, rdy_d;
  logic        done_q, done_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [15:0] a_q, a_d;
  logic [7:0]  d_out_q, d_out_d;
  logic        d_oe_q, d_oe_d;
  logic        mreq_n_q, mreq_n_d;
  logic        iorq_n_q, iorq_n_d;
  logic        rd_n_q, rd_n_d;
  logic        wr_n_q, wr_n_d;

  // Helper terms
  logic        accept;
  logic [7:0]  tw_need;
  logic [7:0]  tw_cnt_inc;
  logic        io_d, wr_d;
  logic        bus_act_d, io_act_d, mem_wr_act_d;

  assign accept     = (state_q == S_IDLE) && req_i;
  assign tw_need    = cmd_q[1] ? IO_TW_L : MEM_TW_L;
  // Saturate so an endless WAIT cannot wrap the counter below tw_need.
  assign tw_cnt_inc = (tw_cnt_q == 8'hFF) ? 8'hFF : tw_cnt_q + 8'd1;

  // State and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cmd_q    <= 2'd0;
      tw_cnt_q <= 8'd0;
      rdy_q    <= 1'b1;
      done_q   <= 1'b0;
      rdata_q  <= 8'd0;
      a_q      <= 16'd0;
      d_out_q  <= 8'd0;
      d_oe_q   <= 1'b0;
      mreq_n_q <= 1'b1;
      iorq_n_q <= 1'b1;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      tw_cnt_q <= tw_cnt_d;
      rdy_q    <= rdy_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      a_q      <= a_d;
      d_out_q  <= d_out_d;
      d_oe_q   <= d_oe_d;
      mreq_n_q <= mreq_n_d;
      iorq_n_q <= iorq_n_d;
      rd_n_q   <= rd_n_d;
      wr_n_q   <= wr_n_d;
    end
  end

  // Next-state: T-state sequencing, automatic waits and WAIT sampling.
  // wait_n_i is only looked at in T2L and TWL, the last L phase before T3.
  always_comb begin
    state_d  = state_q;
    tw_cnt_d = tw_cnt_q;
    case (state_q)
      S_IDLE: if (req_i) state_d = S_T1H;
      S_T1H:  state_d = S_T1L;
      S_T1L:  state_d = S_T2H;
      S_T2H:  state_d = S_T2L;
      S_T2L: begin
        tw_cnt_d = 8'd0;
        if ((tw_need != 8'd0) || !wait_n_i) state_d = S_TWH;
        else                                 state_d = S_T3H;
      end
      S_TWH:  state_d = S_TWL;
      S_TWL: begin
        tw_cnt_d = tw_cnt_inc;
        if ((tw_cnt_inc >= tw_need) && wait_n_i) state_d = S_T3H;
        else                                      state_d = S_TWH;
      end
      S_T3H:  state_d = S_T3L;
      S_T3L:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output next-values, derived from the state being entered so the
  // registered strobes line up exactly with their T-state windows.
  always_comb begin
    cmd_d   = accept ? cmd_i : cmd_q;
    io_d    = cmd_d[1];
    wr_d    = cmd_d[0];

    // Memory strobes: T1L..T3L. IO strobes: T2H..T3L.
    bus_act_d    = (state_d != S_IDLE) && (state_d != S_T1H);
    io_act_d     = bus_act_d && (state_d != S_T1L);
    mem_wr_act_d = (state_d == S_T2L) || (state_d == S_TWH) ||
                   (state_d == S_TWL) || (state_d == S_T3H) ||
                   (state_d == S_T3L);

    mreq_n_d = !(bus_act_d && !io_d);
    iorq_n_d = !(io_act_d && io_d);
    rd_n_d   = !(!wr_d && (io_d ? io_act_d : bus_act_d));
    wr_n_d   = !(wr_d && (io_d ? io_act_d : mem_wr_act_d));
    d_oe_d   = wr_d && bus_act_d;

    rdy_d    = (state_d == S_IDLE);
    done_d   = (state_q == S_T3L);

    // Address and write data are held between cycles.
    a_d      = accept ? addr_i : a_q;
    d_out_d  = (accept && cmd_i[0]) ? wdata_i : d_out_q;

    // Read data captured at the end of T3H.
    rdata_d  = ((state_q == S_T3H) && !cmd_q[0]) ? d_in_i : rdata_q;
  end

  assign rdy_o       = rdy_q;
  assign done_o      = done_q;
  assign rdata_o     = rdata_q;
  assign a_o         = a_q;
  assign d_out_o     = d_out_q;
  assign d_oe_o      = d_oe_q;
  assign mreq_n_o    = mreq_n_q;
  assign iorq_n_o    = iorq_n_q;
  assign rd_n_o      = rd_n_q;
  assign wr_n_o      = wr_n_q;
  assign dbg_state_o = state_q;

endmodule
